stack_memory_controller: RTL

STACK_MEMORY_CONTROLLER -- requirements
Module: stack_memory_controller

---
 rtl/stack_memory_controller_pkg.sv | 19 +
 rtl/data_memory_ram.sv | 22 ++
 rtl/stack_memory_controller.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/stack_memory_controller_pkg.sv
// Shared processor definitions for the stack memory controller: FSM states,
// data word width and the reset stack pointer.
package stack_memory_controller_pkg;

  localparam int unsigned WORD_W = 16;
  localparam int unsigned SP_W   = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PUSH_HI = 2'd1,
    POP_HI  = 2'd2
  } state_t;

  // Stack starts at the top word of memory and grows downward.
  function automatic logic [SP_W-1:0] reset_sp(input int unsigned depth);
    return SP_W'(depth - 1);
  endfunction

endpackage

// File: rtl/data_memory_ram.sv
// Single-port data memory: synchronous write, combinational read, no reset.
module data_memory_ram #(
  parameter int unsigned DEPTH = 4096,
  parameter int unsigned WIDTH = 16,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/stack_memory_controller.sv
// Load/store and descending-stack controller with one- and two-word push/pop.
// Optional macro STACK_GUARD_EN enables overflow/underflow protection.
module stack_memory_controller
  import stack_memory_controller_pkg::*;
#(
  parameter int unsigned MEM_DEPTH   = 4096,
  parameter int unsigned STACK_LIMIT = 2048
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        memory_read,
  input  logic        memory_write,
  input  logic        memory_push,
  input  logic        memory_pop,
  input  logic        push_wide,
  input  logic [15:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] data_r,
  output logic [15:0] sp_r,
  output logic        stall,
  output logic        stack_fault_r
);

  localparam int unsigned AW = $clog2(MEM_DEPTH);
  localparam logic [SP_W-1:0] SP_RESET = reset_sp(MEM_DEPTH);

  state_t            state;
  logic [SP_W-1:0]   sp_inc;
  logic [SP_W-1:0]   sp_dec;
  logic              push_fault;
  logic              pop_fault;
  logic              mem_we;
  logic [AW-1:0]     mem_addr;
  logic [WORD_W-1:0] mem_wdata;
  logic [WORD_W-1:0] mem_rdata;
  logic              unused_addr;

  assign sp_inc      = sp_r + SP_W'(1);
  assign sp_dec      = sp_r - SP_W'(1);
  assign stall       = (state != IDLE);
  assign unused_addr = ^address[15:AW];

`ifdef STACK_GUARD_EN
  assign push_fault = (sp_r < SP_W'(STACK_LIMIT));
  assign pop_fault  = (sp_r == SP_RESET);
`else
  logic unused_cfg;
  assign push_fault = 1'b0;
  assign pop_fault  = 1'b0;
  assign unused_cfg = ^SP_W'(STACK_LIMIT);
`endif

  // Memory port steering; the single port serves whichever request wins.
  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = address[AW-1:0];
    mem_wdata = write_data[15:0];
    case (state)
      IDLE: begin
        if (memory_push) begin
          mem_addr = sp_r[AW-1:0];
          mem_we   = !push_fault;
        end else if (memory_pop) begin
          mem_addr = sp_inc[AW-1:0];
        end else if (memory_write) begin
          mem_we   = 1'b1;
        end
      end
      PUSH_HI: begin
        mem_addr  = sp_r[AW-1:0];
        mem_wdata = write_data[31:16];
        mem_we    = !push_fault;
      end
      POP_HI: begin
        mem_addr = sp_inc[AW-1:0];
      end
      default: ;
    endcase
  end

  data_memory_ram #(
    .DEPTH (MEM_DEPTH),
    .WIDTH (WORD_W)
  ) u_ram (
    .clk   (clk),
    .we    (mem_we),
    .addr  (mem_addr),
    .wdata (mem_wdata),
    .rdata (mem_rdata)
  );

  // Request priority push > pop > write > read; second cycles of wide ops ignore new requests.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      sp_r          <= SP_RESET;
      data_r        <= '0;
      stack_fault_r <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (memory_push) begin
            if (push_fault) begin
              stack_fault_r <= 1'b1;
            end else begin
              sp_r <= sp_dec;
              if (push_wide) state <= PUSH_HI;
            end
          end else if (memory_pop) begin
            if (pop_fault) begin
              stack_fault_r <= 1'b1;
            end else begin
              sp_r <= sp_inc;
              if (push_wide) begin
                data_r[31:16] <= mem_rdata;
                state         <= POP_HI;
              end else begin
                data_r <= {16'h0000, mem_rdata};
              end
            end
          end else if (memory_read && !memory_write) begin
            data_r <= {16'h0000, mem_rdata};
          end
        end
        PUSH_HI: begin
          if (push_fault) stack_fault_r <= 1'b1;
          else            sp_r          <= sp_dec;
          state <= IDLE;
        end
        POP_HI: begin
          if (pop_fault) begin
            stack_fault_r <= 1'b1;
          end else begin
            sp_r         <= sp_inc;
            data_r[15:0] <= mem_rdata;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
